// File: rtl/core_regfile_mp.sv
// core_regfile_mp: parametrised multi-port register file with a per-register
// busy scoreboard. Reads are registered (1-cycle latency). Same-cycle writes
// can optionally be forwarded to reads. Among ports writing one address, the
// highest-numbered port wins. A lock beats a same-cycle write on the busy bit.
module core_regfile_mp #(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 16,
  parameter int N_RD    = 4,
  parameter int N_WR    = 3,
  parameter int BYPASS  = 1,
  parameter int ZERO_R0 = 1,
  localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_RD-1:0][AW-1:0]     rd_r,
  output logic [N_RD-1:0][WIDTH-1:0]  rd_value,
  output logic [N_RD-1:0]             rd_busy,
  input  logic [N_WR-1:0][AW-1:0]     wr_r,
  input  logic [N_WR-1:0]             wr_enable,
  input  logic [N_WR-1:0][WIDTH-1:0]  wr_value,
  input  logic                        lock_enable,
  input  logic [AW-1:0]               lock_r
);

  logic [WIDTH-1:0]             regs_r      [DEPTH];
  logic [WIDTH-1:0]             regs_next_s [DEPTH];
  logic [DEPTH-1:0]             busy_r;
  logic [DEPTH-1:0]             busy_next_s;
  logic [N_RD-1:0][WIDTH-1:0]   rd_value_next_s;
  logic [N_RD-1:0]              rd_busy_next_s;

  // An address is "live" when it names a real register that can hold state:
  // inside DEPTH and not the hardwired zero register.
  function automatic logic addr_live(input logic [AW-1:0] a);
    logic in_range;
    logic is_zero_reg;
    in_range    = (int'(a) < DEPTH);
    is_zero_reg = (ZERO_R0 != 0) && (a == {AW{1'b0}});
    return in_range && !is_zero_reg;
  endfunction

  // Next-state register contents and busy bits: writes in ascending port
  // order so the highest port wins, then the lock so it overrides a clear.
  always_comb begin
    regs_next_s = regs_r;
    busy_next_s = busy_r;
    for (int i = 0; i < N_WR; i++) begin
      if (wr_enable[i] && addr_live(wr_r[i])) begin
        regs_next_s[wr_r[i]] = wr_value[i];
        busy_next_s[wr_r[i]] = 1'b0;
      end else begin
        // idle port or dropped address: no update
      end
    end
    if (lock_enable && addr_live(lock_r)) begin
      busy_next_s[lock_r] = 1'b1;
    end else begin
      // no producer issued this cycle
    end
  end

  // Read-port data selection: forwarded next-state or current contents;
  // dead addresses (zero register, out of range) return zero and not busy.
  always_comb begin
    rd_value_next_s = {(N_RD*WIDTH){1'b0}};
    rd_busy_next_s  = {N_RD{1'b0}};
    for (int j = 0; j < N_RD; j++) begin
      if (addr_live(rd_r[j])) begin
        if (BYPASS != 0) begin
          rd_value_next_s[j] = regs_next_s[rd_r[j]];
          rd_busy_next_s[j]  = busy_next_s[rd_r[j]];
        end else begin
          rd_value_next_s[j] = regs_r[rd_r[j]];
          rd_busy_next_s[j]  = busy_r[rd_r[j]];
        end
      end else begin
        rd_value_next_s[j] = {WIDTH{1'b0}};
        rd_busy_next_s[j]  = 1'b0;
      end
    end
  end

  // State and registered outputs; reset discards all same-cycle activity.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        regs_r[k] <= {WIDTH{1'b0}};
      end
      busy_r   <= {DEPTH{1'b0}};
      rd_value <= {(N_RD*WIDTH){1'b0}};
      rd_busy  <= {N_RD{1'b0}};
    end else begin
      regs_r   <= regs_next_s;
      busy_r   <= busy_next_s;
      rd_value <= rd_value_next_s;
      rd_busy  <= rd_busy_next_s;
    end
  end

endmodule
